// File: rtl/lif_tdm_scheduler.sv
// Four time-multiplexed leaky integrate-and-fire neurons sharing one update unit.
// Optional refractory behaviour is enabled by defining LIF_TDM_REFRACTORY_EN.
module lif_tdm_scheduler #(
    parameter int unsigned THRESHOLD = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] cur_a,
    input  logic [7:0] cur_b,
    output logic       out_valid,
    output logic [3:0] spikes,
    input  logic [1:0] state_sel,
    output logic [7:0] state_out,
    output logic [7:0] spike_count
);

    localparam logic [7:0] Thresh = 8'(THRESHOLD);

    typedef enum logic [1:0] {
        StIdle,
        StSlot,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [7:0]  mem_q [4];
    logic [3:0]  spikes_q;
    logic [7:0]  count_q;
    logic [7:0]  cur_a_q, cur_b_q;

    logic        accept;
    logic        upd_en;
    logic [7:0]  upd_cur;
    logic [7:0]  upd_prior;
    logic        upd_fire;
    logic signed [9:0] upd_sum;
    logic [7:0]  upd_state;
    logic        upd_spike;

`ifdef LIF_TDM_REFRACTORY_EN
    logic [3:0]  refr_q;
`endif

    // Control FSM: one idle cycle, four update slots, one completion cycle.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        upd_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StSlot;
                    slot_d  = 2'd0;
                end
            end
            StSlot: begin
                upd_en = 1'b1;
                if (slot_q == 2'd3) begin
                    state_d = StDone;
                    slot_d  = 2'd0;
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
                slot_d  = 2'd0;
            end
        endcase
    end

    // Odd neurons are driven by the freshly written state of their even partner.
    always_comb begin
        upd_cur = cur_a_q;
        unique case (slot_q)
            2'd0: upd_cur = cur_a_q;
            2'd1: upd_cur = mem_q[0];
            2'd2: upd_cur = cur_b_q;
            2'd3: upd_cur = mem_q[2];
            default: upd_cur = cur_a_q;
        endcase
    end

    always_comb begin
        upd_prior = mem_q[slot_q];
        upd_fire  = (upd_prior >= Thresh);
        upd_sum   = $signed({2'b00, upd_cur}) + $signed({3'b000, upd_prior[7:1]})
                  - (upd_fire ? $signed({2'b00, Thresh}) : 10'sd0);
        if (upd_sum < 10'sd0) begin
            upd_state = 8'd0;
        end else if (upd_sum > 10'sd255) begin
            upd_state = 8'd255;
        end else begin
            upd_state = upd_sum[7:0];
        end
        upd_spike = upd_fire;
`ifdef LIF_TDM_REFRACTORY_EN
        if (refr_q[slot_q]) begin
            upd_state = 8'd0;
            upd_spike = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            slot_q   <= 2'd0;
            spikes_q <= 4'b0000;
            count_q  <= 8'd0;
            cur_a_q  <= 8'd0;
            cur_b_q  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'd0;
            end
`ifdef LIF_TDM_REFRACTORY_EN
            refr_q <= 4'b0000;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (accept) begin
                cur_a_q <= cur_a;
                cur_b_q <= cur_b;
            end
            if (upd_en) begin
                mem_q[slot_q]    <= upd_state;
                spikes_q[slot_q] <= upd_spike;
                count_q          <= count_q + {7'd0, upd_spike};
`ifdef LIF_TDM_REFRACTORY_EN
                refr_q[slot_q]   <= upd_spike;
`endif
            end
        end
    end

    assign spikes      = spikes_q;
    assign spike_count = count_q;
    assign state_out   = mem_q[state_sel];

endmodule
